// File: rtl/inst_loader.sv
// Purpose : assemble four debounced switch bytes into a 32-bit word and write it to instruction RAM.
// Latency : press -> word_buf/byte_cnt next cycle; 4th press -> Mem_wea pulse next cycle, address bump after it.
// Backpressure: none; presses arriving during the write cycle or once full are dropped.
//
// Ports:
//   Clk        system clock, all state on rising edge
//   Rst        synchronous active-high reset
//   Button     raw bouncy push button (high = pressed)
//   Data_in    switch byte captured on each debounced press
//   Mem_wea    one-cycle RAM write strobe per assembled word
//   Mem_addra  RAM word address (current word_addr)
//   Mem_dina   RAM write data (current word_buf)
//   LED        {byte_cnt, word_addr} progress display
//   Full       high once all 64 words have been written
module inst_loader #(
  parameter int SAMPLE_DIV = 2500000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Button,
  input  logic [7:0]  Data_in,
  output logic        Mem_wea,
  output logic [5:0]  Mem_addra,
  output logic [31:0] Mem_dina,
  output logic [7:0]  LED,
  output logic        Full
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_WRITE   = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  // Button synchronizer: deliberately not reset, it only tracks the pin.
  logic btn_meta;
  logic btn_sync;

  always_ff @(posedge Clk) begin
    btn_meta <= Button;
    btn_sync <= btn_meta;
  end

  // Debounce sample tick.
  logic [CW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Three-sample debouncer. The level decision uses the values being shifted
  // in on this tick ({btn_sync, q1, q2} become {q1, q2, q3}), so db_level
  // changes in the cycle right after the third agreeing tick.
  logic q1;
  logic q2;
  logic q3;
  logic db_level;
  logic db_level_d;
  logic press;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q1         <= 1'b0;
      q2         <= 1'b0;
      q3         <= 1'b0;
      db_level   <= 1'b0;
      db_level_d <= 1'b0;
    end else begin
      db_level_d <= db_level;
      if (tick) begin
        q1 <= btn_sync;
        q2 <= q1;
        q3 <= q2;
        if (btn_sync && q1 && q2) begin
          db_level <= 1'b1;
        end else if (!btn_sync && !q1 && !q2) begin
          db_level <= 1'b0;
        end
      end
    end
  end

  // Rising edge of the debounced level only; release never produces a press.
  assign press = db_level & ~db_level_d;

  // Word assembly FSM and datapath.
  state_t      state;
  state_t      state_nx;
  logic [1:0]  byte_cnt;
  logic [1:0]  byte_cnt_nx;
  logic [5:0]  word_addr;
  logic [5:0]  word_addr_nx;
  logic [31:0] word_buf;
  logic [31:0] word_buf_nx;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_COLLECT;
      byte_cnt  <= 2'd0;
      word_addr <= 6'd0;
      word_buf  <= 32'd0;
    end else begin
      state     <= state_nx;
      byte_cnt  <= byte_cnt_nx;
      word_addr <= word_addr_nx;
      word_buf  <= word_buf_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    byte_cnt_nx  = byte_cnt;
    word_addr_nx = word_addr;
    word_buf_nx  = word_buf;
    case (state)
      S_COLLECT: begin
        if (press) begin
          // Little-endian lanes: first byte lands in [7:0].
          word_buf_nx[{byte_cnt, 3'b000} +: 8] = Data_in;
          if (byte_cnt == 2'd3) begin
            byte_cnt_nx = 2'd0;
            state_nx    = S_WRITE;
          end else begin
            byte_cnt_nx = byte_cnt + 2'd1;
          end
        end
      end
      S_WRITE: begin
        // Any press in this cycle is intentionally dropped.
        if (word_addr == 6'd63) begin
          state_nx = S_FULL;
        end else begin
          word_addr_nx = word_addr + 6'd1;
          state_nx     = S_COLLECT;
        end
      end
      S_FULL: begin
        state_nx = S_FULL;
      end
      default: begin
        state_nx = S_COLLECT;
      end
    endcase
  end

  // The RAM ignores address/data while the strobe is low, so drive them always.
  assign Mem_wea   = (state == S_WRITE);
  assign Mem_addra = word_addr;
  assign Mem_dina  = word_buf;
  assign LED       = {byte_cnt, word_addr};
  assign Full      = (state == S_FULL);

endmodule
